// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding, load-use stall and bubble insertion.
// Define ID_EX_FWD_EN for EX/MEM and MEM/WB forwarding; otherwise RAW hazards on EX and MEM stall instead.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_alu_control,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_dest,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_dest,
  input  logic [DATA_W-1:0] memwb_result,
  input  logic              ext_stall,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_control,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_dest,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              hazard_stall
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic [3:0]        alu_control;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_state_t;

  ex_state_t         state_q, state_d;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic              load_use;
  logic              raw_stall;

  assign ex_valid      = state_q.valid;
  assign ex_dest       = state_q.dest;
  assign alu_control   = state_q.alu_control;
  assign ex_reg_write  = state_q.valid & state_q.reg_write;
  assign ex_mem_read   = state_q.valid & state_q.mem_read;
  assign ex_mem_write  = state_q.valid & state_q.mem_write;
  assign ex_mem_to_reg = state_q.valid & state_q.mem_to_reg;

  assign alu_in1       = opnd_a;
  assign alu_in2       = state_q.alu_src ? state_q.imm : opnd_b;
  assign ex_store_data = opnd_b;

  // A load in EX cannot feed ID's rs, ALU rt, or store data until it reaches WB.
  assign load_use = ex_valid && ex_mem_read && (ex_dest != '0) && id_valid &&
                    ((id_rs == ex_dest) || ((id_rt == ex_dest) && (!id_alu_src || id_mem_write)));

`ifdef ID_EX_FWD_EN
  always_comb begin
    opnd_a = state_q.rs_data;
    if (exmem_reg_write && (exmem_dest == state_q.rs) && (state_q.rs != '0))
      opnd_a = exmem_result;
    else if (memwb_reg_write && (memwb_dest == state_q.rs) && (state_q.rs != '0))
      opnd_a = memwb_result;
  end

  always_comb begin
    opnd_b = state_q.rt_data;
    if (exmem_reg_write && (exmem_dest == state_q.rt) && (state_q.rt != '0))
      opnd_b = exmem_result;
    else if (memwb_reg_write && (memwb_dest == state_q.rt) && (state_q.rt != '0))
      opnd_b = memwb_result;
  end

  assign raw_stall = 1'b0;
`else
  logic unused_fwd;

  assign opnd_a = state_q.rs_data;
  assign opnd_b = state_q.rt_data;

  // MEM/WB needs no stall: the register file writes before it is read.
  assign raw_stall = id_valid && (
      ((id_rs != '0) && ((ex_reg_write && (id_rs == ex_dest)) || (exmem_reg_write && (id_rs == exmem_dest)))) ||
      ((id_rt != '0) && ((ex_reg_write && (id_rt == ex_dest)) || (exmem_reg_write && (id_rt == exmem_dest)))));

  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_dest, memwb_result, state_q.rs, state_q.rt};
`endif

  assign hazard_stall = load_use || raw_stall;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = '0;
    end else if (!ext_stall) begin
      if (hazard_stall) begin
        state_d = '0;
      end else begin
        state_d.valid       = id_valid;
        state_d.rs_data     = id_rs_data;
        state_d.rt_data     = id_rt_data;
        state_d.imm         = id_imm;
        state_d.rs          = id_rs;
        state_d.rt          = id_rt;
        state_d.dest        = id_reg_dst ? id_rd : id_rt;
        state_d.alu_control = id_alu_control;
        state_d.alu_src     = id_alu_src;
        state_d.reg_write   = id_reg_write;
        state_d.mem_read    = id_mem_read;
        state_d.mem_write   = id_mem_write;
        state_d.mem_to_reg  = id_mem_to_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

endmodule
